seven_segment_hex_decoder: RTL and testbench

Recovers hex digits from a multiplexed, active-high seven-segment display bus (one-hot digit select plus shared segment lines) and presents them as a nibble table. Each digit/segment combination must be stable for a set number of cycles before it is accepted. Changes to the table are handed downstream as snapshots over a valid/ready handshake. It is the readback counterpart of the hex-to-seven-segment converter and sits behind the display driver for self-check and loopback.

---
 rtl/seven_segment_hex_decoder_if.sv | 28 ++
 rtl/seven_segment_hex_decoder.sv | 172 +++++++++++++++++
 tb/tb_seven_segment_hex_decoder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_hex_decoder_if.sv
// Bus bundle between the seven-segment readback decoder and its environment.
// Carries the multiplexed display bus in, the live nibble table out, and the
// snapshot valid/ready handshake; master = environment side, slave = decoder.
interface seven_segment_hex_decoder_if #(
   parameter int DIGITS = 4
);
   logic [6:0]          seven_segment;     // g f e d c b a, active-high
   logic [DIGITS-1:0]   digit_select;      // one-hot digit enable
   logic [4*DIGITS-1:0] hex_table;         // live nibbles, digit i at [4i+3:4i]
   logic [DIGITS-1:0]   hex_table_valid;   // live per-digit glyph-legal flags
   logic                update_valid;      // snapshot available
   logic                update_ready;      // downstream takes snapshot
   logic [4*DIGITS-1:0] update_hex;        // frozen copy of hex_table
   logic [DIGITS-1:0]   update_hex_valid;  // frozen copy of hex_table_valid
   logic                decode_error;      // one-cycle illegal-commit pulse

   modport master (
      output seven_segment, digit_select, update_ready,
      input  hex_table, hex_table_valid, update_valid,
             update_hex, update_hex_valid, decode_error
   );

   modport slave (
      input  seven_segment, digit_select, update_ready,
      output hex_table, hex_table_valid, update_valid,
             update_hex, update_hex_valid, decode_error
   );
endinterface

// File: rtl/seven_segment_hex_decoder.sv
// Recovers hex digits from a multiplexed seven-segment bus into a nibble table
// and hands table changes downstream as snapshots over valid/ready.
// Ports: clk, rst (sync, active-high), bus (slave modport of the decoder interface).
// Latency: commit on the STABLE_CYCLES-th identical capture, snapshot one edge later.
// Backpressure: the snapshot stays frozen while update_ready is low; later commits
// are remembered in a dirty flag and presented after the accept.
module seven_segment_hex_decoder #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   seven_segment_hex_decoder_if.slave  bus
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

   logic [6:0]          r_seg;
   logic [DIGITS-1:0]   r_sel;
   logic [CW-1:0]       r_cnt;
   logic [4*DIGITS-1:0] r_hex_table;
   logic [DIGITS-1:0]   r_hex_vld;
   logic [4*DIGITS-1:0] r_upd_hex;
   logic [DIGITS-1:0]   r_upd_vld;
   logic                r_dirty;
   logic                r_decode_error;
   state_t              r_state;

   logic                w_in_onehot;
   logic                w_same;
   logic                w_commit;
   logic [4*DIGITS-1:0] w_hex_next;
   logic [DIGITS-1:0]   w_vld_next;
   logic                w_change;
   logic                w_illegal;
   logic [4:0]          w_dec;
   logic                w_load;
   state_t              w_state_next;

   // Returns {legal, nibble} for a segment pattern.
   function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         7'h3F:   res = {1'b1, 4'h0};
         7'h06:   res = {1'b1, 4'h1};
         7'h5B:   res = {1'b1, 4'h2};
         7'h4F:   res = {1'b1, 4'h3};
         7'h66:   res = {1'b1, 4'h4};
         7'h6D:   res = {1'b1, 4'h5};
         7'h7D:   res = {1'b1, 4'h6};
         7'h07:   res = {1'b1, 4'h7};
         7'h7F:   res = {1'b1, 4'h8};
         7'h6F:   res = {1'b1, 4'h9};
         7'h77:   res = {1'b1, 4'hA};
         7'h7C:   res = {1'b1, 4'hB};
         7'h39:   res = {1'b1, 4'hC};
         7'h5E:   res = {1'b1, 4'hD};
         7'h79:   res = {1'b1, 4'hE};
         7'h71:   res = {1'b1, 4'hF};
         default: res = {1'b0, 4'h0};
      endcase
      return res;
   endfunction

   // The run counter is advanced at capture time: the value entering the sample
   // register is compared with the one already held, so r_cnt equals the number
   // of identical captures including the current edge. The commit itself only
   // uses the registered sample, which equals the incoming value when w_same.
   assign w_in_onehot = (bus.digit_select != '0) &&
                        ((bus.digit_select & (bus.digit_select - DIGITS'(1))) == '0);
   assign w_same      = (bus.seven_segment == r_seg) && (bus.digit_select == r_sel);
   assign w_commit    = w_in_onehot && w_same && (r_cnt == CW'(STABLE_CYCLES - 1));
   assign w_dec       = glyph_decode(r_seg);

   // Post-commit table and change detection.
   always_comb begin
      w_hex_next = r_hex_table;
      w_vld_next = r_hex_vld;
      w_illegal  = 1'b0;
      if (w_commit) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (r_sel[i]) begin
               if (w_dec[4]) begin
                  w_hex_next[4*i +: 4] = w_dec[3:0];
                  w_vld_next[i]        = 1'b1;
               end else if (r_seg == 7'h00) begin
                  w_hex_next[4*i +: 4] = 4'h0;
                  w_vld_next[i]        = 1'b0;
               end else begin
                  // Unknown glyph: nibble kept, only the valid bit drops.
                  w_vld_next[i]        = 1'b0;
                  w_illegal            = 1'b1;
               end
            end
         end
      end
      w_change = (w_hex_next != r_hex_table) || (w_vld_next != r_hex_vld);
   end

   // Handshake FSM next state. Snapshots always load from the post-commit table
   // so a commit landing on the load edge is never lost.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_dirty) begin
               w_load       = 1'b1;
               w_state_next = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (bus.update_ready) begin
               if (r_dirty || w_change) begin
                  w_load = 1'b1;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg          <= '0;
         r_sel          <= '0;
         r_cnt          <= '0;
         r_hex_table    <= '0;
         r_hex_vld      <= '0;
         r_upd_hex      <= '0;
         r_upd_vld      <= '0;
         r_dirty        <= 1'b0;
         r_decode_error <= 1'b0;
         r_state        <= ST_IDLE;
      end else begin
         r_seg <= bus.seven_segment;
         r_sel <= bus.digit_select;

         if (!w_in_onehot) begin
            r_cnt <= '0;
         end else if (!w_same) begin
            r_cnt <= CW'(1);
         end else if (r_cnt != CW'(STABLE_CYCLES)) begin
            r_cnt <= r_cnt + CW'(1);
         end

         r_hex_table    <= w_hex_next;
         r_hex_vld      <= w_vld_next;
         r_decode_error <= w_illegal;

         if (w_load) begin
            r_upd_hex <= w_hex_next;
            r_upd_vld <= w_vld_next;
            r_dirty   <= 1'b0;
         end else if (w_change) begin
            r_dirty   <= 1'b1;
         end

         r_state <= w_state_next;
      end
   end

   assign bus.hex_table        = r_hex_table;
   assign bus.hex_table_valid  = r_hex_vld;
   assign bus.update_valid     = (r_state == ST_PRESENT);
   assign bus.update_hex       = r_upd_hex;
   assign bus.update_hex_valid = r_upd_vld;
   assign bus.decode_error     = r_decode_error;
endmodule

// File: tb/tb_seven_segment_hex_decoder.sv
// Self-checking bench for seven_segment_hex_decoder (DIGITS=4, STABLE_CYCLES=4).
// Expected snapshots are queued when the stimulus that causes them is driven
// and compared whenever the DUT hands a snapshot over the valid/ready handshake.
module tb_seven_segment_hex_decoder;
   localparam int DIGITS = 4;
   localparam int STABLE = 4;

   typedef struct packed {
      logic [15:0] hex;
      logic [3:0]  vld;
   } snap_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seven_segment_hex_decoder_if #(.DIGITS(DIGITS)) bus ();

   seven_segment_hex_decoder #(
      .DIGITS        (DIGITS),
      .STABLE_CYCLES (STABLE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   snap_t sb_q[$];
   int    n_vec      = 0;
   int    n_err      = 0;
   int    err_pulses = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [3:0] sel, input logic [6:0] seg);
      bus.digit_select  = sel;
      bus.seven_segment = seg;
   endtask

   task automatic push(input logic [15:0] hex, input logic [3:0] vld);
      snap_t s;
      s.hex = hex;
      s.vld = vld;
      sb_q.push_back(s);
   endtask

   // Scoreboard: inputs only change just after posedge, so what is seen here is
   // what the next posedge accepts.
   always @(negedge clk) begin
      if (!rst && bus.update_valid && bus.update_ready) begin
         snap_t s;
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", 32'd1, 32'd0);
         end else begin
            s = sb_q.pop_front();
            chk("sb_hex", 32'(bus.update_hex), 32'(s.hex));
            chk("sb_vld", 32'(bus.update_hex_valid), 32'(s.vld));
         end
      end
      if (!rst && bus.decode_error) err_pulses++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic bad;
      int   e0;

      rst = 1'b1;
      bus.update_ready = 1'b0;
      drive(4'b0000, 7'h00);

      // Reset with random inputs.
      repeat (2) begin
         drive(4'($urandom), 7'($urandom));
         bus.update_ready = 1'($urandom);
         step(1);
      end
      chk("rst_hex",  32'(bus.hex_table), 32'h0);
      chk("rst_hv",   32'(bus.hex_table_valid), 32'h0);
      chk("rst_uv",   32'(bus.update_valid), 32'h0);
      chk("rst_uhex", 32'(bus.update_hex), 32'h0);
      chk("rst_uhv",  32'(bus.update_hex_valid), 32'h0);
      chk("rst_err",  32'(bus.decode_error), 32'h0);
      drive(4'b0000, 7'h00);
      bus.update_ready = 1'b0;
      rst = 1'b0;
      bus.update_ready = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         step(1);
         bad |= bus.update_valid;
      end
      chk("idle_uv", 32'(bad), 32'h0);
      bus.update_ready = 1'b0;

      // Commit and hold: digit 0 shows "2".
      drive(4'b0001, 7'h5B);
      step(3);
      chk("pre_commit_hex", 32'(bus.hex_table), 32'h0);
      step(1);
      chk("commit_hex", 32'(bus.hex_table), 32'h0002);
      chk("commit_hv",  32'(bus.hex_table_valid), 32'h1);
      chk("commit_uv",  32'(bus.update_valid), 32'h0);
      push(16'h0002, 4'b0001);
      step(1);
      chk("present_uv",   32'(bus.update_valid), 32'h1);
      chk("present_uhex", 32'(bus.update_hex), 32'h0002);
      chk("present_uhv",  32'(bus.update_hex_valid), 32'h1);
      step(1);
      drive(4'b0000, 7'h00);
      bad = 1'b0;
      repeat (10) begin
         step(1);
         bad |= (bus.update_valid !== 1'b1) || (bus.update_hex !== 16'h0002);
      end
      chk("hold_stable", 32'(bad), 32'h0);
      bus.update_ready = 1'b1;
      step(1);
      bus.update_ready = 1'b0;
      chk("accept_drop_uv", 32'(bus.update_valid), 32'h0);

      // Glitch: "A" held one edge short of the threshold.
      e0 = err_pulses;
      drive(4'b0010, 7'h77);
      step(3);
      drive(4'b0010, 7'h00);
      step(6);
      chk("glitch_hex", 32'(bus.hex_table), 32'h0002);
      chk("glitch_hv",  32'(bus.hex_table_valid), 32'h1);
      chk("glitch_uv",  32'(bus.update_valid), 32'h0);
      chk("glitch_err", 32'(err_pulses - e0), 32'h0);
      drive(4'b0000, 7'h00);
      step(1);

      // Digit 2 gets "3", then an illegal glyph, then blank.
      drive(4'b0100, 7'h4F);
      step(4);
      chk("d2_hex", 32'(bus.hex_table), 32'h0302);
      push(16'h0302, 4'b0101);
      step(1);
      chk("d2_uv", 32'(bus.update_valid), 32'h1);
      bus.update_ready = 1'b1;
      step(1);
      bus.update_ready = 1'b0;

      e0 = err_pulses;
      drive(4'b0100, 7'h7E);
      step(3);
      chk("ill_pre_err", 32'(bus.decode_error), 32'h0);
      step(1);
      chk("ill_err", 32'(bus.decode_error), 32'h1);
      chk("ill_hex", 32'(bus.hex_table), 32'h0302);
      chk("ill_hv",  32'(bus.hex_table_valid), 32'h1);
      push(16'h0302, 4'b0001);
      step(1);
      chk("ill_err_gone", 32'(bus.decode_error), 32'h0);
      chk("ill_uv",       32'(bus.update_valid), 32'h1);
      chk("ill_uhv",      32'(bus.update_hex_valid), 32'h1);
      bus.update_ready = 1'b1;
      step(1);
      bus.update_ready = 1'b0;

      drive(4'b0100, 7'h00);
      step(4);
      chk("blank_hex", 32'(bus.hex_table), 32'h0002);
      chk("blank_hv",  32'(bus.hex_table_valid), 32'h1);
      chk("blank_err", 32'(bus.decode_error), 32'h0);
      push(16'h0002, 4'b0001);
      step(1);
      chk("blank_uv",   32'(bus.update_valid), 32'h1);
      chk("blank_uhex", 32'(bus.update_hex), 32'h0002);
      bus.update_ready = 1'b1;
      step(1);
      bus.update_ready = 1'b0;

      drive(4'b0000, 7'h00);
      step(1);
      drive(4'b0100, 7'h00);
      step(8);
      chk("rep_uv",  32'(bus.update_valid), 32'h0);
      chk("ill_err_count", 32'(err_pulses - e0), 32'h1);

      // Select faults never commit.
      e0 = err_pulses;
      bad = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive((k == 0) ? 4'b0011 : 4'b0000, 7'h3F);
         repeat (20) begin
            step(1);
            bad |= bus.update_valid || (bus.hex_table !== 16'h0002);
         end
      end
      chk("sel_fault", 32'(bad), 32'h0);
      chk("sel_fault_err", 32'(err_pulses - e0), 32'h0);

      // Commit landing on the accept edge.
      drive(4'b0001, 7'h06);
      step(4);
      push(16'h0001, 4'b0001);
      step(1);
      chk("sim_uv", 32'(bus.update_valid), 32'h1);
      drive(4'b0010, 7'h71);
      step(3);
      bus.update_ready = 1'b1;
      step(1);
      push(16'h00F1, 4'b0011);
      bus.update_ready = 1'b0;
      chk("sim_uv_hold", 32'(bus.update_valid), 32'h1);
      chk("sim_uhex",    32'(bus.update_hex), 32'h00F1);
      chk("sim_uhv",     32'(bus.update_hex_valid), 32'h3);
      drive(4'b0000, 7'h00);
      step(1);
      bus.update_ready = 1'b1;
      step(1);
      bus.update_ready = 1'b0;
      chk("sim_uv_drop", 32'(bus.update_valid), 32'h0);

      // Reset while a snapshot is pending discards it.
      drive(4'b1000, 7'h7F);
      step(5);
      chk("mr_uv", 32'(bus.update_valid), 32'h1);
      rst = 1'b1;
      step(1);
      chk("mr_uv_rst", 32'(bus.update_valid), 32'h0);
      chk("mr_hex",    32'(bus.hex_table), 32'h0);
      drive(4'b0000, 7'h00);
      rst = 1'b0;
      bus.update_ready = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         step(1);
         bad |= bus.update_valid;
      end
      bus.update_ready = 1'b0;
      chk("mr_idle", 32'(bad), 32'h0);

      chk("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
